// File: rtl/inv_sbox_engine.sv
// Iterative AES InvSubBytes: one 128-bit state in, LANES bytes substituted per cycle,
// finished state presented with a valid/ready handshake. Inverse S-box is computed, not tabled.
module inv_sbox_engine #(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int unsigned N  = 16 / LANES;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("inv_sbox_engine: LANES must be one of 1, 2, 4, 8, 16");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [127:0]   work_q, work_d;
  logic [127:0]   out_data_q, out_data_d;
  logic [127:0]   work_sub;
  int unsigned    base;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x   = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // a^254 == a^-1 in GF(2^8); the chain naturally maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int unsigned i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  always_comb begin
    work_sub = work_q;
    base     = 32'(cnt_q) * LANES;
    for (int unsigned l = 0; l < LANES; l++) begin
      work_sub[127 - 8*(base + l) -: 8] = inv_sbox(work_q[127 - 8*(base + l) -: 8]);
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    out_data_d = out_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        work_d = work_sub;
        if (cnt_q == LAST) begin
          cnt_d      = '0;
          out_data_d = work_sub;
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      work_q     <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      out_data_q <= out_data_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_inv_sbox_engine.sv
// Bench for inv_sbox_engine: cycle model built from the forward S-box, plus directed
// vectors for the known block, corner bytes, backpressure, abort and a LANES sweep.
`timescale 1ns/1ps
module tb_inv_sbox_engine;

  localparam int unsigned LANES = 4;
  localparam int unsigned N     = 16 / LANES;
  localparam logic [127:0] KNOWN_IN   = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [127:0] KNOWN_OUT  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CORNER_IN  = 128'h006316ed7c6363636363636363636363;
  localparam logic [127:0] CORNER_OUT = 128'h5200ff53010000000000000000000000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_data = '0;
  logic         in_ready, out_valid, busy;
  logic [127:0] out_data;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  inv_sbox_engine #(.LANES(LANES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  localparam int unsigned SW_LANES [4] = '{1, 2, 8, 16};
  localparam int          SW_LAT   [4] = '{16, 8, 2, 1};
  logic [3:0]   sw_in_valid = '0;
  logic [3:0]   sw_in_ready, sw_out_valid, sw_busy;
  logic [127:0] sw_out_data [4];

  for (genvar g = 0; g < 4; g++) begin : g_sw
    inv_sbox_engine #(.LANES(SW_LANES[g])) u_sw (
      .clk(clk), .rst(rst), .in_valid(sw_in_valid[g]), .in_ready(sw_in_ready[g]),
      .in_data(in_data), .out_valid(sw_out_valid[g]), .out_ready(1'b0),
      .out_data(sw_out_data[g]), .busy(sw_busy[g])
    );
  end

  // Reference tables: forward S-box from a brute-force field inverse, then inverted.
  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= 15'(a) << i;
    for (int i = 14; i >= 8; i--) if (p[i]) p ^= 15'h11b << (i - 8);
    return p[7:0];
  endfunction

  function automatic logic [7:0] tb_rotl(input logic [7:0] v, input int k);
    logic [7:0] r;
    r = (v << k) | (v >> (8 - k));
    return r;
  endfunction

  function automatic logic [127:0] model_block(input logic [127:0] d);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = inv_tab[d[127-8*i -: 8]];
    return r;
  endfunction

  task automatic build_tables();
    logic [7:0] iv;
    logic [7:0] xb;
    for (int x = 0; x < 256; x++) begin
      xb = 8'(x);
      iv = '0;
      for (int y = 1; y < 256; y++) if (tb_gmul(xb, 8'(y)) == 8'h01) iv = 8'(y);
      fwd_tab[x] = iv ^ tb_rotl(iv, 1) ^ tb_rotl(iv, 2) ^ tb_rotl(iv, 3) ^ tb_rotl(iv, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Cycle model: count down N edges after accept, then hold the result until out_ready.
  logic         m_busy = 1'b0;
  logic         m_out_valid = 1'b0;
  logic [127:0] m_out_data = '0;
  logic [127:0] m_pending = '0;
  int           m_left = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy      <= 1'b0;
      m_out_valid <= 1'b0;
      m_out_data  <= '0;
      m_left      <= 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy    <= 1'b1;
        m_left    <= N;
        m_pending <= model_block(in_data);
      end
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_out_valid <= 1'b1;
        m_out_data  <= m_pending;
      end
    end else if (out_ready) begin
      m_out_valid <= 1'b0;
      m_busy      <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mdl_in_ready", in_ready, !rst && !m_busy);
      chk("mdl_busy", busy, m_busy);
      chk("mdl_out_valid", out_valid, m_out_valid);
      chk("mdl_out_data", out_data, m_out_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_block(input string nm, input logic [127:0] d, input logic [127:0] exp);
    int lat;
    chk({nm, "_ready"}, in_ready, 1'b1);
    in_data  = d;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    chk({nm, "_latency"}, lat, N);
    chk({nm, "_data"}, out_data, exp);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [127:0] d, e;
    int lat [4];
    build_tables();

    chk("pin_inv_00", inv_tab[8'h00], 8'h52);
    chk("pin_inv_63", inv_tab[8'h63], 8'h00);
    chk("pin_inv_16", inv_tab[8'h16], 8'hff);
    chk("pin_inv_ed", inv_tab[8'hed], 8'h53);
    chk("pin_inv_7c", inv_tab[8'h7c], 8'h01);
    chk("pin_fwd_53", fwd_tab[8'h53], 8'hed);
    chk("pin_known", model_block(KNOWN_IN), KNOWN_OUT);

    // Reset
    rst = 1'b1;
    step();
    step();
    chk_en = 1'b1;
    chk("rst_in_ready_low", in_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_busy", busy, 1'b0);

    // Known block and corner bytes
    run_block("known", KNOWN_IN, KNOWN_OUT);
    run_block("corner", CORNER_IN, CORNER_OUT);

    // Round trip over all 256 values, 16 per block
    for (int b = 0; b < 16; b++) begin
      for (int i = 0; i < 16; i++) begin
        d[127-8*i -: 8] = fwd_tab[b*16 + i];
        e[127-8*i -: 8] = 8'(b*16 + i);
      end
      run_block($sformatf("rtrip%0d", b), d, e);
    end

    // Backpressure in DONE
    in_data  = KNOWN_IN;
    in_valid = 1'b1;
    step();
    for (int k = 0; k < 40 && !out_valid; k++) step();
    for (int k = 0; k < 10; k++) begin
      step();
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_out_data", out_data, KNOWN_OUT);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    in_data   = CORNER_IN;
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_done", in_ready, 1'b0);
    step();
    out_ready = 1'b0;
    chk("bp_release_ready", in_ready, 1'b1);
    chk("bp_release_busy", busy, 1'b0);
    step();
    in_valid = 1'b0;
    chk("bp_next_busy", busy, 1'b1);
    for (int k = 0; k < 40 && !out_valid; k++) step();
    chk("bp_next_data", out_data, CORNER_OUT);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Abort two cycles after accept
    in_data  = KNOWN_IN;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_out_data", out_data, '0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("abort_out_valid", out_valid, 1'b0);
    end
    run_block("after_abort", KNOWN_IN, KNOWN_OUT);

    // LANES sweep
    chk("sw_ready", sw_in_ready, 4'hf);
    in_data     = KNOWN_IN;
    sw_in_valid = 4'hf;
    step();
    sw_in_valid = '0;
    chk("sw_busy", sw_busy, 4'hf);
    for (int g = 0; g < 4; g++) lat[g] = 0;
    for (int k = 1; k <= 20; k++) begin
      for (int g = 0; g < 4; g++) if (sw_out_valid[g] && lat[g] == 0) lat[g] = k - 1;
      step();
    end
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("sw%0d_latency", SW_LANES[g]), lat[g], SW_LAT[g]);
      chk($sformatf("sw%0d_data", SW_LANES[g]), sw_out_data[g], KNOWN_OUT);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
